// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result bundle between a requester and seq_alu
interface seq_alu_if #(parameter int WIDTH = 32) ();
  logic             start;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             div_by_zero;
  modport master (output start, alu_op, a, b, input busy, done, result, result_hi, zero, div_by_zero);
  modport slave (input start, alu_op, a, b, output busy, done, result, result_hi, zero, div_by_zero);
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with shift-add MUL and optional restoring DIVU (enabled by SEQ_ALU_DIVU_EN)
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  seq_alu_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, m;
  logic [WIDTH-1:0] nh, nl, sc_res, sc_hi;
  logic [WIDTH:0]   sum;
  logic             sc_dbz, long_op, div_r;
  logic [SW-1:0]    shamt;
  assign shamt = bus.b[SW-1:0];
  assign bus.busy = state == EXEC;
  assign bus.done = state == DONE;
  // single-cycle results, plus whether the request needs the iterative datapath
  always_comb begin
    sc_res = '0;
    sc_hi = '0;
    sc_dbz = 1'b0;
    case (bus.alu_op)
      4'b0000: sc_res = bus.a & bus.b;
      4'b0001: sc_res = bus.a | bus.b;
      4'b0010: sc_res = ~(bus.a | bus.b);
      4'b0011: sc_res = bus.a + bus.b;
      4'b0100: sc_res = bus.a - bus.b;
      4'b0101: sc_res = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'b0110: sc_res = bus.a << shamt;
      4'b0111: sc_res = bus.a >> shamt;
`ifdef SEQ_ALU_DIVU_EN
      OP_DIVU: begin
        sc_res = '1;
        sc_hi = bus.a;
        sc_dbz = 1'b1;
      end
`endif
      default: sc_res = '0;
    endcase
`ifdef SEQ_ALU_DIVU_EN
    long_op = bus.alu_op == OP_MUL || (bus.alu_op == OP_DIVU && |bus.b);
`else
    long_op = bus.alu_op == OP_MUL;
`endif
  end
  // one iteration: hi/lo hold product (MUL) or remainder/quotient-shifting-dividend (DIVU)
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    nh = {sum[WIDTH], sum[WIDTH-1:1]};
    nl = {sum[0], lo[WIDTH-1:1]};
`ifdef SEQ_ALU_DIVU_EN
    if (div_r) begin
      nh = ({hi, lo[WIDTH-1]} >= {1'b0, m}) ? {hi[WIDTH-2:0], lo[WIDTH-1]} - m : {hi[WIDTH-2:0], lo[WIDTH-1]};
      nl = {lo[WIDTH-2:0], {hi, lo[WIDTH-1]} >= {1'b0, m}};
    end
`endif
  end
  // control FSM; outputs are written only when entering DONE so partials never leak
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      m <= '0;
      div_r <= 1'b0;
      bus.result <= '0;
      bus.result_hi <= '0;
      bus.zero <= 1'b1;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          if (long_op) begin
            state <= EXEC;
            cnt <= CW'(WIDTH);
            hi <= '0;
            div_r <= bus.alu_op == OP_DIVU;
            lo <= bus.alu_op == OP_MUL ? bus.b : bus.a;
            m <= bus.alu_op == OP_MUL ? bus.a : bus.b;
          end else begin
            state <= DONE;
            bus.result <= sc_res;
            bus.result_hi <= sc_hi;
            bus.zero <= sc_res == '0;
            bus.div_by_zero <= sc_dbz;
          end
        end
        EXEC: begin
          hi <= nh;
          lo <= nl;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            bus.result <= nl;
            bus.result_hi <= nh;
            bus.zero <= nl == '0;
            bus.div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu (WIDTH=32)
module tb_seq_alu;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  int lat, busy_n, done_n;
  always #5 clk = ~clk;
  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv, input bit poke);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.alu_op = op;
    bus.a = av;
    bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    lat = 1;
    busy_n = 0;
    while (!bus.done && lat < 100) begin
      busy_n += int'(bus.busy);
      if (poke && lat == 5) begin
        bus.start = 1'b1;
        bus.alu_op = 4'b0011;
      end
      if (poke && lat == 6) bus.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.alu_op = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_hi", bus.result_hi, 0);
    chk("rst_zero", bus.zero, 1);
    chk("rst_dbz", bus.div_by_zero, 0);
    reset = 1'b0;
    run(4'b0011, 32'hFFFF_FFFF, 32'd1, 0);
    chk("add_lat", lat, 1);
    chk("add_busy", busy_n + int'(bus.busy), 0);
    chk("add_res", bus.result, 0);
    chk("add_zero", bus.zero, 1);
    run(4'b0101, 32'h0, 32'h0000_1234, 0);
    chk("lui_res", bus.result, 32'h1234_0000);
    chk("lui_zero", bus.zero, 0);
    run(4'b0111, 32'h8000_0000, 32'd31, 0);
    chk("srl_lat", lat, 1);
    chk("srl_res", bus.result, 1);
    bus.start = 1'b1;
    bus.alu_op = 4'b0011;
    bus.a = 32'd7;
    bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("done_ign_pulse", bus.done, 0);
    @(posedge clk); #1;
    chk("done_ign_done", bus.done, 0);
    chk("done_ign_res", bus.result, 1);
    run(4'b0100, 32'd3, 32'd5, 0);
    chk("sub_res", bus.result, 32'hFFFF_FFFE);
    run(4'b0010, 32'h0F0F_0F0F, 32'h00FF_00FF, 0);
    chk("nor_res", bus.result, 32'hF000_F000);
    run(4'b0001, 32'h0F0F_0F0F, 32'h00FF_00FF, 0);
    chk("or_res", bus.result, 32'h0FFF_0FFF);
    run(4'b0000, 32'h0F0F_0F0F, 32'h00FF_00FF, 0);
    chk("and_res", bus.result, 32'h000F_000F);
    run(4'b0110, 32'd1, 32'h0000_0023, 0);
    chk("sll_res", bus.result, 32'd8);
    run(4'b1111, 32'd5, 32'd6, 0);
    chk("undef_res", {bus.result_hi, bus.result}, 0);
    chk("undef_zero", bus.zero, 1);
    run(4'b1000, 32'hFFFF_FFFF, 32'd2, 1);
    chk("mul_lat", lat, 33);
    chk("mul_busy", busy_n, 32);
    chk("mul_prod", {bus.result_hi, bus.result}, 64'h1_FFFF_FFFE);
    chk("mul_zero", bus.zero, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mul_hold", {bus.result_hi, bus.result}, 64'h1_FFFF_FFFE);
    run(4'b1000, 32'h0001_0000, 32'h0001_0000, 0);
    chk("mul_big", {bus.result_hi, bus.result}, 64'h1_0000_0000);
    chk("mul_big_zero", bus.zero, 1);
    run(4'b1001, 32'd100, 32'd7, 0);
`ifdef SEQ_ALU_DIVU_EN
    chk("div_lat", lat, 33);
    chk("div_res", {bus.result_hi, bus.result}, {32'd2, 32'd14});
    run(4'b1001, 32'hFFFF_FFFF, 32'h10, 0);
    chk("div_big", {bus.result_hi, bus.result}, {32'hF, 32'h0FFF_FFFF});
    run(4'b1001, 32'd5, 32'd0, 0);
    chk("div0_lat", lat, 1);
    chk("div0_res", {bus.result_hi, bus.result}, {32'd5, 32'hFFFF_FFFF});
    chk("div0_flag", bus.div_by_zero, 1);
`else
    chk("div_lat", lat, 1);
    chk("div_res", {bus.result_hi, bus.result}, 0);
    chk("div_zero", bus.zero, 1);
    run(4'b1001, 32'd5, 32'd0, 0);
    chk("div0_res", {bus.result_hi, bus.result}, 0);
    chk("div0_flag", bus.div_by_zero, 0);
`endif
    run(4'b0000, 32'hFF, 32'h0F, 0);
    chk("dbz_clear", bus.div_by_zero, 0);
    chk("dbz_clear_res", bus.result, 32'h0F);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.alu_op = 4'b1000;
    bus.a = 32'd9;
    bus.b = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_n = 0;
    repeat (9) begin
      done_n += int'(bus.done);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_res", {bus.result_hi, bus.result}, 0);
    chk("abort_zero", bus.zero, 1);
    repeat (40) begin
      done_n += int'(bus.done);
      @(posedge clk); #1;
    end
    chk("abort_nodone", done_n, 0);
    run(4'b0011, 32'd2, 32'd3, 0);
    chk("post_add", bus.result, 5);
    chk("post_lat", lat, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
